// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file definitions used by the write-back arbiter and its
// neighbours (address/data widths, the hard-wired zero register).
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_DATA_W-1:0] reg_data_t;

   localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bundle between the execute/memory stages and the
// register-file write-back arbiter.
//   req_valid  per-source write request
//   req_addr   destination register, source i at [i*ADDR_W +: ADDR_W]
//   req_data   write data, source i at [i*DATA_W +: DATA_W]
//   req_ready  one-hot grant back to the sources
// master: the write-back sources; slave: the arbiter.
interface regfile_wb_arbiter_if
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = REG_DATA_W,
   parameter int ADDR_W  = REG_ADDR_W
);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;

   modport master (
      output req_valid,
      output req_addr,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      input  req_data,
      output req_ready
   );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// scanning upward and wrapping. The pointer moves past the winner on a grant
// and holds otherwise.
//   clock, reset  clock / async active-high reset (pointer -> 0)
//   enable        0 = no grant this cycle
//   req           request vector
//   gnt           one-hot grant (combinational)
module rr_arbiter #(
   parameter int NUM_REQ = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_next;
   logic [PTR_W-1:0] cand;

   // Scan from the farthest offset down to the pointer itself so the
   // nearest requester at or after the pointer is the last one written.
   always_comb begin
      gnt      = '0;
      ptr_next = ptr;
      cand     = '0;
      if (enable) begin
         for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (req[cand]) begin
               gnt      = NUM_REQ'(1) << cand;
               ptr_next = PTR_W'((int'(cand) + 1) % NUM_REQ);
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else begin
         ptr <= ptr_next;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: shares the single register-file write
// port between NUM_REQ sources with round-robin grant and valid/ready
// handshake, one registered output stage, $0 write suppression and a
// committed-write counter.
//   clock, reset   clock / async active-high reset
//   wb_stall       1 = issue no grants this cycle
//   req_if         write-back request bundle (slave side)
//   wr_en/addr/data registered register-file write port
//   wr_src         source index owning the current write
//   wr_count       committed (non-$0) writes, wraps
// Optional macro REGFILE_BYPASS_EN adds a two-read-port forwarding path
// (byp_addr_sX/byp_rf_sX in, byp_data_sX out) so a read in the write cycle
// sees the new value.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = REG_DATA_W,
   parameter int ADDR_W  = REG_ADDR_W,
   parameter int CNT_W   = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       wb_stall,
   regfile_wb_arbiter_if.slave        req_if,
`ifdef REGFILE_BYPASS_EN
   input  logic [ADDR_W-1:0]          byp_addr_s1,
   input  logic [ADDR_W-1:0]          byp_addr_s2,
   input  logic [DATA_W-1:0]          byp_rf_s1,
   input  logic [DATA_W-1:0]          byp_rf_s2,
   output logic [DATA_W-1:0]          byp_data_s1,
   output logic [DATA_W-1:0]          byp_data_s2,
`endif
   output logic                       wr_en,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic [DATA_W-1:0]          wr_data,
   output logic [$clog2(NUM_REQ)-1:0] wr_src,
   output logic [CNT_W-1:0]           wr_count
);

   localparam int SRC_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] gnt;
   logic               grant_en;
   logic               accept;
   logic               commit;
   logic [SRC_W-1:0]   sel_idx;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;

   // No grants while reset is held, so a source never sees ready for a
   // request the output stage cannot take.
   assign grant_en = ~wb_stall & ~reset;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .clock  (clock),
      .reset  (reset),
      .enable (grant_en),
      .req    (req_if.req_valid),
      .gnt    (gnt)
   );

   assign req_if.req_ready = gnt;

   always_comb begin
      sel_idx  = '0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_idx  = SRC_W'(i);
            sel_addr = req_if.req_addr[i*ADDR_W +: ADDR_W];
            sel_data = req_if.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign accept = |gnt;
   // $0 requests complete the handshake but never reach the register file.
   assign commit = accept & (sel_addr != ADDR_W'(REG_ZERO));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         wr_src   <= '0;
         wr_count <= '0;
      end else begin
         wr_en <= commit;
         if (commit) begin
            wr_addr  <= sel_addr;
            wr_data  <= sel_data;
            wr_src   <= sel_idx;
            wr_count <= wr_count + 1'b1;
         end
      end
   end

`ifdef REGFILE_BYPASS_EN
   assign byp_data_s1 = (wr_en && (wr_addr == byp_addr_s1) && (byp_addr_s1 != ADDR_W'(REG_ZERO)))
                        ? wr_data : byp_rf_s1;
   assign byp_data_s2 = (wr_en && (wr_addr == byp_addr_s2) && (byp_addr_s2 != ADDR_W'(REG_ZERO)))
                        ? wr_data : byp_rf_s2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

   localparam int N     = 3;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int CW    = 4;
   localparam int CMOD  = 1 << CW;

   logic          clock = 1'b0;
   logic          reset;
   logic          wb_stall;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [1:0]    wr_src;
   logic [CW-1:0] wr_count;
`ifdef REGFILE_BYPASS_EN
   logic [AW-1:0] byp_addr_s1, byp_addr_s2;
   logic [DW-1:0] byp_rf_s1, byp_rf_s2, byp_data_s1, byp_data_s2;
`endif

   regfile_wb_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) rif ();

   regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clock       (clock),
      .reset       (reset),
      .wb_stall    (wb_stall),
      .req_if      (rif.slave),
`ifdef REGFILE_BYPASS_EN
      .byp_addr_s1 (byp_addr_s1),
      .byp_addr_s2 (byp_addr_s2),
      .byp_rf_s1   (byp_rf_s1),
      .byp_rf_s2   (byp_rf_s2),
      .byp_data_s1 (byp_data_s1),
      .byp_data_s2 (byp_data_s2),
`endif
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_src      (wr_src),
      .wr_count    (wr_count)
   );

   always #5 clock = ~clock;

   // Minimal register file sitting behind the write port.
   logic [DW-1:0] rf [32];
   always @(posedge clock) if (wr_en) rf[wr_addr] <= wr_data;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: next-source pointer and the expected write-port state.
   int            m_ptr   = 0;
   logic          m_wr_en = 1'b0;
   logic [AW-1:0] m_addr  = '0;
   logic [DW-1:0] m_data  = '0;
   int            m_src   = 0;
   int            m_count = 0;
   int            last_gnt;
   logic [N-1:0]  ready_seen;

   logic [AW-1:0] s_addr [N];
   logic [DW-1:0] s_data [N];
   logic [N-1:0]  pend;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [N-1:0] v);
      rif.req_valid = v;
      for (int i = 0; i < N; i++) begin
         rif.req_addr[i*AW +: AW] = s_addr[i];
         rif.req_data[i*DW +: DW] = s_data[i];
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_wr_en = 1'b0; m_addr = '0; m_data = '0; m_src = 0; m_count = 0;
   endtask

   // One clock cycle: check the grant mid-cycle, cross the edge, check the
   // registered write port against the model.
   task automatic step();
      logic [N-1:0] eg;
      int gi;
      #1;
      eg = '0;
      gi = -1;
      if (!reset && !wb_stall)
         for (int k = 0; k < N; k++)
            if (gi < 0 && rif.req_valid[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
      if (gi >= 0) eg[gi] = 1'b1;
      ready_seen = rif.req_ready;
      chk("req_ready", 64'(ready_seen), 64'(eg));
      @(posedge clock);
      #1;
      if (reset) begin
         model_reset();
      end else if (gi >= 0 && s_addr[gi] != '0) begin
         m_ptr   = (gi + 1) % N;
         m_wr_en = 1'b1;
         m_addr  = s_addr[gi];
         m_data  = s_data[gi];
         m_src   = gi;
         m_count = (m_count + 1) % CMOD;
      end else begin
         if (gi >= 0) m_ptr = (gi + 1) % N;
         m_wr_en = 1'b0;
      end
      last_gnt = gi;
      chk("wr_en", 64'(wr_en), 64'(m_wr_en));
      chk("wr_addr", 64'(wr_addr), 64'(m_addr));
      chk("wr_data", 64'(wr_data), 64'(m_data));
      chk("wr_src", 64'(wr_src), 64'(m_src));
      chk("wr_count", 64'(wr_count), 64'(m_count));
   endtask

   initial begin
      reset    = 1'b1;
      wb_stall = 1'b0;
      for (int i = 0; i < N; i++) begin
         s_addr[i] = AW'(i + 1);
         s_data[i] = DW'(32'h100 + i);
      end
      drive(3'b111);
`ifdef REGFILE_BYPASS_EN
      byp_addr_s1 = '0; byp_addr_s2 = '0; byp_rf_s1 = '0; byp_rf_s2 = '0;
`endif
      #2;
      chk("rst_ready", 64'(rif.req_ready), 64'(0));
      chk("rst_wr_en", 64'(wr_en), 64'(0));
      chk("rst_count", 64'(wr_count), 64'(0));
      chk("rst_addr", 64'(wr_addr), 64'(0));
      step();
      reset = 1'b0;

      // Round robin with all three sources valid.
      step(); chk("rr0_src", 64'(wr_src), 64'(0)); chk("rr0_addr", 64'(wr_addr), 64'(1));
      step(); chk("rr1_src", 64'(wr_src), 64'(1)); chk("rr1_addr", 64'(wr_addr), 64'(2));
      step(); chk("rr2_src", 64'(wr_src), 64'(2)); chk("rr2_addr", 64'(wr_addr), 64'(3));
      step(); chk("rr3_src", 64'(wr_src), 64'(0)); chk("rr3_addr", 64'(wr_addr), 64'(1));
      chk("rr_count", 64'(wr_count), 64'(4));

      // $0 filter: source 1 targets r0, source 2 waits behind it.
      s_addr[1] = '0; s_data[1] = 32'hDEADBEEF;
      s_addr[2] = AW'(9); s_data[2] = 32'h209;
      drive(3'b110);
      step();
      chk("zero_ready", 64'(ready_seen), 64'(3'b010));
      chk("zero_wr_en", 64'(wr_en), 64'(0));
      chk("zero_count", 64'(wr_count), 64'(4));
      drive(3'b100);
      step();
      chk("zero_next_ready", 64'(ready_seen), 64'(3'b100));
      chk("zero_next_addr", 64'(wr_addr), 64'(9));

      // Stall with source 2 pending.
      s_addr[2] = AW'(10); s_data[2] = 32'hCAFE;
      drive(3'b100);
      wb_stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("stall_ready", 64'(ready_seen), 64'(0));
         chk("stall_wr_en", 64'(wr_en), 64'(0));
      end
      wb_stall = 1'b0;
      step();
      chk("unstall_ready", 64'(ready_seen), 64'(3'b100));
      chk("unstall_data", 64'(wr_data), 64'(32'hCAFE));
      chk("unstall_addr", 64'(wr_addr), 64'(10));

      // Reset while a write to r5 is registered but not yet committed.
      s_addr[0] = AW'(5); s_data[0] = 32'h1111;
      drive(3'b001); step();
      drive(3'b000); step();
      s_data[0] = 32'h1234;
      drive(3'b001); step();
      chk("mid_wr_en_pre", 64'(wr_en), 64'(1));
      drive(3'b000);
      reset = 1'b1;
      #1;
      chk("mid_wr_en", 64'(wr_en), 64'(0));
      chk("mid_count", 64'(wr_count), 64'(0));
      @(posedge clock);
      #1;
      chk("mid_r5", 64'(rf[5]), 64'(32'h1111));
      model_reset();
      reset = 1'b0;

`ifdef REGFILE_BYPASS_EN
      s_addr[0] = AW'(7); s_data[0] = 32'hA5A5A5A5;
      drive(3'b001); step();
      drive(3'b000);
      byp_addr_s1 = AW'(7); byp_addr_s2 = '0;
      byp_rf_s1 = 32'h11; byp_rf_s2 = 32'h22;
      #1;
      chk("byp_s1", 64'(byp_data_s1), 64'(32'hA5A5A5A5));
      chk("byp_s2", 64'(byp_data_s2), 64'(32'h22));
      byp_addr_s2 = AW'(7);
      byp_addr_s1 = AW'(8);
      #1;
      chk("byp_s1_miss", 64'(byp_data_s1), 64'(32'h11));
      chk("byp_s2_hit", 64'(byp_data_s2), 64'(32'hA5A5A5A5));
`endif

      // Randomised traffic: sources hold requests until granted, random stalls,
      // occasional $0 targets; the 4-bit counter wraps several times.
      pend = '0;
      drive(pend);
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(1, 0) == 1) begin
               pend[i]   = 1'b1;
               s_addr[i] = ($urandom_range(7, 0) == 0) ? '0 : AW'($urandom_range(31, 1));
               s_data[i] = $urandom;
            end
         end
         wb_stall = ($urandom_range(3, 0) == 0);
         drive(pend);
         step();
         if (last_gnt >= 0) pend[last_gnt] = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
